// File: rtl/float_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with
// round-to-nearest-even, flush-to-zero and special-value handling.
module float_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int M    = MAN_W + 1;
  localparam int P    = 2 * M;
  localparam int EW2  = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EW2-1:0] EMAX_S = EW2'(EMAX);
  localparam logic signed [EW2-1:0] ZERO_S = '0;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  logic za, zb, ia, ib, na, nb;
  logic c_nan, c_inf, c_zero;
  logic signed [EW2-1:0] esum;

  // Classify operands and form the biased exponent sum.
  always_comb begin
    za     = (ea == '0);
    zb     = (eb == '0);
    ia     = (&ea) && (fa == '0);
    ib     = (&eb) && (fb == '0);
    na     = (&ea) && (fa != '0);
    nb     = (&eb) && (fb != '0);
    c_nan  = na || nb || (ia && zb) || (ib && za);
    c_inf  = ia || ib;
    c_zero = za || zb;
    esum   = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
  end

  logic                  v1, s1, nan1, inf1, zero1;
  logic signed [EW2-1:0] e1;
  logic [M-1:0]          ma1, mb1;

  // Stage 1: unpacked operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      nan1  <= 1'b0;
      inf1  <= 1'b0;
      zero1 <= 1'b0;
      e1    <= '0;
      ma1   <= '0;
      mb1   <= '0;
    end else if (en) begin
      v1    <= in_valid;
      s1    <= sa ^ sb;
      nan1  <= c_nan;
      inf1  <= c_inf;
      zero1 <= c_zero;
      e1    <= esum;
      ma1   <= {1'b1, fa};
      mb1   <= {1'b1, fb};
    end
  end

  logic                  v2, s2, nan2, inf2, zero2;
  logic signed [EW2-1:0] e2;
  logic [P-1:0]          p2;

  // Stage 2: full-width mantissa product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      s2    <= 1'b0;
      nan2  <= 1'b0;
      inf2  <= 1'b0;
      zero2 <= 1'b0;
      e2    <= '0;
      p2    <= '0;
    end else if (en) begin
      v2    <= v1;
      s2    <= s1;
      nan2  <= nan1;
      inf2  <= inf1;
      zero2 <= zero1;
      e2    <= e1;
      p2    <= P'(ma1) * P'(mb1);
    end
  end

  logic                  msb, guard, sticky, rnd, carry;
  logic [MAN_W-1:0]      frac, frac_r;
  logic signed [EW2-1:0] efin;
  logic [EXP_W+MAN_W:0]  res_n;
  logic                  ovf_n, unf_n, inv_n;

  // Normalise, round to nearest even, then apply special cases.
  always_comb begin
    msb    = p2[P-1];
    frac   = msb ? p2[P-2 -: MAN_W] : p2[P-3 -: MAN_W];
    guard  = msb ? p2[M-1] : p2[M-2];
    sticky = msb ? |p2[M-2:0] : |p2[M-3:0];
    rnd    = guard && (sticky || frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    efin   = e2 + EW2'(msb) + EW2'(carry);
    res_n  = {s2, efin[EXP_W-1:0], frac_r};
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    inv_n  = 1'b0;
    if (nan2) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      inv_n = 1'b1;
    end else if (inf2) begin
      res_n = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero2) begin
      res_n = {s2, {(EXP_W+MAN_W){1'b0}}};
    end else if (efin >= EMAX_S) begin
      res_n = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (efin <= ZERO_S) begin
      res_n = {s2, {(EXP_W+MAN_W){1'b0}}};
      unf_n = 1'b1;
    end
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      if (v2) begin
        result    <= res_n;
        overflow  <= ovf_n;
        underflow <= unf_n;
        invalid   <= inv_n;
      end
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe: directed vectors, streaming with
// backpressure, async reset and a half-precision instance.
module tb_float_mult_pipe;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        u;
    logic        i;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] a = 0, b = 0, result;
  logic        overflow, underflow, invalid;

  logic        h_in_valid = 0, h_in_ready, h_out_valid, h_out_ready = 1;
  logic [15:0] h_a = 0, h_b = 0, h_result;
  logic        h_overflow, h_underflow, h_invalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .underflow(underflow), .invalid(invalid)
  );

  float_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .overflow(h_overflow),
    .underflow(h_underflow), .invalid(h_invalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, rounded by quotient/remainder.
  function automatic exp_t model(input int ew, input int mw,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   m;
    longint one = 1;
    longint emax = (one << ew) - 1;
    longint bias = (one << (ew - 1)) - 1;
    longint fmask = (one << mw) - 1;
    longint av = {32'b0, x};
    longint bv = {32'b0, y};
    longint fa = av & fmask;
    longint fb = bv & fmask;
    longint ea = (av >> mw) & emax;
    longint eb = (bv >> mw) & emax;
    longint s = ((av ^ bv) >> (ew + mw)) & 1;
    bit za = (ea == 0);
    bit zb = (eb == 0);
    bit ia = (ea == emax) && (fa == 0);
    bit ib = (eb == emax) && (fb == 0);
    bit na = (ea == emax) && (fa != 0);
    bit nb = (eb == emax) && (fb != 0);
    longint p, q, rem, half, e, r;
    int sh;
    m = '0;
    if (na || nb || (ia && zb) || (ib && za)) begin
      r = (emax << mw) | (one << (mw - 1));
      m.i = 1'b1;
    end else if (ia || ib) begin
      r = (s << (ew + mw)) | (emax << mw);
    end else if (za || zb) begin
      r = s << (ew + mw);
    end else begin
      p = (fa | (one << mw)) * (fb | (one << mw));
      sh = (p >= (one << (2 * mw + 1))) ? mw + 1 : mw;
      e = ea + eb - bias + longint'(sh - mw);
      q = p >> sh;
      rem = p & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        r = (s << (ew + mw)) | (emax << mw);
        m.o = 1'b1;
      end else if (e <= 0) begin
        r = s << (ew + mw);
        m.u = 1'b1;
      end else begin
        r = (s << (ew + mw)) | (e << mw) | (q & fmask);
      end
    end
    m.r = r[31:0];
    return m;
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    longint one = 1;
    longint emax = (one << ew) - 1;
    longint s = longint'($urandom_range(0, 1));
    longint f = longint'($urandom) & ((one << mw) - 1);
    longint e;
    longint v;
    int k = $urandom_range(0, 11);
    if (k == 0) e = 0;
    else if (k == 1) begin e = emax; f = 0; end
    else if (k == 2) begin e = emax; f = f | 1; end
    else if (k == 3) e = longint'($urandom) & emax;
    else e = longint'($urandom_range(1, 32'(emax - 1)));
    v = (s << (ew + mw)) | (e << mw) | f;
    return v[31:0];
  endfunction

  task automatic dir(input string tag, input logic [31:0] x,
                     input logic [31:0] y, input exp_t ex);
    int n;
    out_ready = 1;
    in_valid = 1;
    a = x;
    b = y;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, {result, overflow, underflow, invalid}, ex);
    step();
  endtask

  task automatic hdir(input string tag, input logic [15:0] x,
                      input logic [15:0] y, input logic [15:0] er,
                      input logic eo, input logic eu, input logic ei);
    int n;
    h_out_ready = 1;
    h_in_valid = 1;
    h_a = x;
    h_b = y;
    step();
    h_in_valid = 0;
    n = 1;
    while (!h_out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, {h_result, h_overflow, h_underflow, h_invalid},
        {er, eo, eu, ei});
    step();
  endtask

  task automatic stream(input int n, input bit stall_mode);
    exp_t        q[$];
    exp_t        ex;
    int          sent = 0;
    int          cyc = 0;
    bit          was_stall = 0;
    logic [31:0] held = 0;
    while ((sent < n || q.size() > 0) && cyc < 3000) begin
      if (stall_mode) out_ready = (cyc < 2) || (cyc >= 14);
      else out_ready = ($urandom_range(0, 3) != 0);
      if (sent < n) begin
        in_valid = stall_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        a = rand_op(8, 23);
        b = rand_op(8, 23);
      end else begin
        in_valid = 0;
      end
      #1;
      if (was_stall) chk("stall_hold", {out_valid, result}, {1'b1, held});
      was_stall = out_valid && !out_ready;
      held = result;
      if (stall_mode && cyc == 10) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          ex = q.pop_front();
          chk("stream_res", {result, overflow, underflow, invalid}, ex);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(8, 23, a, b));
        sent++;
      end
      step();
      cyc++;
    end
    chk("stream_done", {32'(sent), 32'(q.size())}, {32'(n), 32'd0});
    in_valid = 0;
    out_ready = 1;
    step();
  endtask

  initial begin
    bit          seen;
    logic [31:0] x, y;
    exp_t        hx;
    #12;
    chk("rst_state", {out_valid, result, overflow, underflow, invalid},
        37'd0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    step();

    dir("mul_1p5x2", 32'h3FC00000, 32'h40000000,
        {32'h40400000, 3'b000});
    dir("mul_neg", 32'hBF000000, 32'h40C00000,
        {32'hC0400000, 3'b000});
    dir("tie_even", 32'h3F800800, 32'h3F800800,
        {32'h3F801000, 3'b000});
    dir("ovf", 32'h7F000000, 32'h40000000,
        {32'h7F800000, 3'b100});
    dir("unf", 32'h00800000, 32'h3F000000,
        {32'h00000000, 3'b010});
    dir("inf_x_zero", 32'h7F800000, 32'h00000000,
        {32'h7FC00000, 3'b001});
    dir("neg_inf", 32'hFF800000, 32'h3F800000,
        {32'hFF800000, 3'b000});
    dir("neg_zero", 32'h80000000, 32'h3F800000,
        {32'h80000000, 3'b000});
    dir("nan_in", 32'h7F800001, 32'h40000000,
        {32'h7FC00000, 3'b001});

    for (int i = 0; i < 12; i++) begin
      x = rand_op(8, 23);
      y = rand_op(8, 23);
      dir("rand_dir", x, y, model(8, 23, x, y));
    end

    stream(8, 1'b1);
    stream(200, 1'b0);

    out_ready = 1;
    in_valid = 1;
    a = 32'h3FC00000;
    b = 32'h40000000;
    step();
    a = 32'h40000000;
    step();
    in_valid = 0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("async_rst", {out_valid, result, overflow, underflow, invalid},
        37'd0);
    step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk("no_stale", seen, 0);

    hdir("h_mul", 16'h3E00, 16'h4000, 16'h4200, 1'b0, 1'b0, 1'b0);
    hdir("h_ovf", 16'h7800, 16'h4000, 16'h7C00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      x = {16'h0, rand_op(5, 10)};
      y = {16'h0, rand_op(5, 10)};
      hx = model(5, 10, x, y);
      hdir("h_rand", x[15:0], y[15:0], hx.r[15:0], hx.o, hx.u, hx.i);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
